tile_buf_ctrl: RTL and testbench

Sequencer for the 8x8 byte tile buffer. On `start` it fetches a 64-byte tile from the shared SRAM as 8 rows of 8 bytes, writes each byte into the tile buffer, then drains the buffer back to SRAM as 32 16-bit words. It sits between the SRAM port arbiter, which supplies `sram_gnt`, and the tile buffer, and replaces ad-hoc sequencing inside the buffer.

---
 rtl/tile_buf_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_tile_buf_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_buf_ctrl.sv
// tile_buf_ctrl: sequencer for the 8x8 byte tile buffer.
//
// On an accepted start it reads a 64-byte tile from SRAM as 8 rows of 8 bytes
// (rows ROW_STRIDE bytes apart) and writes each byte into the tile buffer. It then
// drains the buffer back to SRAM as 32 consecutive 16-bit words.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   start, abort        begin a tile (IDLE only) / synchronous cancel
//   src_base, dst_base  tile source and destination byte addresses, latched on start
//   busy, done          not-idle flag / one-cycle completion pulse
//   sram_req, sram_we   SRAM access request and direction (1 = write)
//   sram_addr           SRAM access address
//   sram_gnt            arbiter grant; an access happens when req & gnt
//   sram_rdata          read byte, valid RD_LAT cycles after a granted read
//   sram_wdata          write word (pass-through of buf_rdata while draining)
//   buf_wen/waddr/wdata tile buffer byte write port
//   buf_raddr/rdata     tile buffer combinational word read port
module tile_buf_ctrl #(
  parameter int unsigned AW         = 18,
  parameter int unsigned RD_LAT     = 1,   // legal 1..3
  parameter int unsigned ROW_STRIDE = 256
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          busy,
  output logic          done,
  output logic          sram_req,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  input  logic          sram_gnt,
  input  logic [7:0]    sram_rdata,
  output logic [15:0]   sram_wdata,
  output logic          buf_wen,
  output logic [5:0]    buf_waddr,
  output logic [7:0]    buf_wdata,
  output logic [4:0]    buf_raddr,
  input  logic [15:0]   buf_rdata
);

  localparam int unsigned Last = RD_LAT - 1;

  typedef enum logic [2:0] {StIdle, StFill, StFlush, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic   [5:0]           rd_cnt_q, rd_cnt_d;
  logic   [6:0]           ret_cnt_q, ret_cnt_d;
  logic   [4:0]           dr_cnt_q, dr_cnt_d;
  logic   [AW-1:0]        src_base_q, src_base_d;
  logic   [AW-1:0]        dst_base_q, dst_base_d;
  logic   [RD_LAT-1:0]    pipe_vld_q, pipe_vld_d;
  logic   [RD_LAT-1:0][5:0] pipe_tag_q, pipe_tag_d;

  logic          accept;
  logic          kill;
  logic          rd_fire;
  logic          wr_fire;
  logic          ret_fire;
  logic [AW-1:0] row_off;
  logic [AW-1:0] fill_addr;

  assign accept   = (state_q == StIdle) && start;
  assign kill     = abort && (state_q != StIdle);
  assign rd_fire  = (state_q == StFill) && sram_gnt;
  assign wr_fire  = (state_q == StDrain) && sram_gnt;
  assign ret_fire = pipe_vld_q[Last];

  // Row/column split of the read counter; sums wrap modulo 2^AW.
  assign row_off   = AW'(ROW_STRIDE) * AW'(rd_cnt_q[5:3]);
  assign fill_addr = src_base_q + row_off + AW'(rd_cnt_q[2:0]);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFill;
      StFill:  if (sram_gnt && (rd_cnt_q == 6'd63)) state_d = StFlush;
      // Wait until every granted read has landed in the buffer.
      StFlush: if (ret_cnt_q == 7'd64) state_d = StDrain;
      StDrain: if (sram_gnt && (dr_cnt_q == 5'd31)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides any transition taken this cycle.
    if (kill) state_d = StIdle;
  end

  // Counters, latched bases and read-return pipe
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    ret_cnt_d  = ret_cnt_q;
    dr_cnt_d   = dr_cnt_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    if (accept) begin
      rd_cnt_d   = '0;
      ret_cnt_d  = '0;
      dr_cnt_d   = '0;
      src_base_d = src_base;
      dst_base_d = dst_base;
    end else begin
      if (rd_fire)  rd_cnt_d  = rd_cnt_q + 6'd1;
      if (ret_fire) ret_cnt_d = ret_cnt_q + 7'd1;
      if (wr_fire)  dr_cnt_d  = dr_cnt_q + 5'd1;
    end
  end

  // Each granted read carries its buffer byte index until the data returns.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_tag_d    = pipe_tag_q;
    pipe_vld_d[0] = rd_fire;
    pipe_tag_d[0] = rd_cnt_q;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
    if (kill) pipe_vld_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_cnt_q   <= '0;
      ret_cnt_q  <= '0;
      dr_cnt_q   <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      pipe_vld_q <= '0;
      pipe_tag_q <= '0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      dr_cnt_q   <= dr_cnt_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
    end
  end

  // Outputs
  always_comb begin
    busy       = (state_q != StIdle);
    done       = 1'b0;
    sram_req   = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    buf_raddr  = '0;
    unique case (state_q)
      StFill: begin
        sram_req  = 1'b1;
        sram_addr = fill_addr;
      end
      StDrain: begin
        sram_req   = 1'b1;
        sram_we    = 1'b1;
        buf_raddr  = dr_cnt_q;
        sram_addr  = dst_base_q + AW'(dr_cnt_q);
        sram_wdata = buf_rdata;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
    // Returns are captured in any state; the pipe is empty outside FILL/FLUSH.
    buf_wen   = ret_fire;
    buf_waddr = ret_fire ? pipe_tag_q[Last] : 6'd0;
    buf_wdata = ret_fire ? sram_rdata : 8'd0;
  end

endmodule

// File: tb/tb_tile_buf_ctrl.sv
// Directed bench for tile_buf_ctrl. Three instances run in lock-step with RD_LAT 1, 2, 3
// sharing control inputs; each has its own SRAM read-latency model and tile buffer model.
module tb_tile_buf_ctrl;

  logic        clock, reset, start, abort, gnt;
  logic [17:0] src_base, dst_base;
  logic        busy [3], done [3], req [3], we [3], wen [3];
  logic [17:0] addr [3];
  logic [15:0] wdata [3], brd [3];
  logic [7:0]  rdata [3], bwdata [3];
  logic [5:0]  waddr [3];
  logic [4:0]  raddr [3];

  logic [7:0]  tbuf [3][64];
  logic        hv [3][4];
  logic [17:0] ha [3][4];
  logic [2:0]  row0;
  int          gmode;
  int          cnum, t0;
  int          checks, passes;

  int          busy_n [3], first_busy [3], done_n [3], done_rel [3];
  int          wen_n [3], last_wen [3], rd_n [3], wr_n [3], first_wr [3];
  int          stab_err [3], stall_n [3];
  logic        stall_q [3];
  logic [17:0] stall_a [3];
  logic [15:0] stall_d [3];
  logic [17:0] rd_a [3][64];
  logic [17:0] wr_a [3][32];
  logic [15:0] wr_d [3][32];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tile_buf_ctrl #(.AW(18), .RD_LAT(g + 1), .ROW_STRIDE(256)) u_dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .src_base(src_base), .dst_base(dst_base), .busy(busy[g]), .done(done[g]),
      .sram_req(req[g]), .sram_we(we[g]), .sram_addr(addr[g]), .sram_gnt(gnt),
      .sram_rdata(rdata[g]), .sram_wdata(wdata[g]), .buf_wen(wen[g]),
      .buf_waddr(waddr[g]), .buf_wdata(bwdata[g]), .buf_raddr(raddr[g]),
      .buf_rdata(brd[g]));
    assign brd[g] = {tbuf[g][{raddr[g], 1'b0}], tbuf[g][{raddr[g], 1'b1}]};
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM content: (row << 3) | col, with the row field taken relative to the tile's
  // first row so that buffer byte k ends up holding k for any source base.
  function automatic logic [7:0] sram_byte(input logic [17:0] a);
    logic [2:0] r;
    r = a[10:8] - row0;
    return {2'b00, r, a[2:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clr_logs();
    for (int k = 0; k < 3; k++) begin
      busy_n[k] = 0; first_busy[k] = -1; done_n[k] = 0; done_rel[k] = -1;
      wen_n[k] = 0; last_wen[k] = -1; rd_n[k] = 0; wr_n[k] = 0; first_wr[k] = -1;
      stab_err[k] = 0; stall_n[k] = 0; stall_q[k] = 1'b0;
      for (int b = 0; b < 64; b++) tbuf[k][b] = 8'hFF;
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, observe 1 ns later.
  task automatic step(input logic st, input logic ab);
    int rel;
    @(negedge clock);
    start = st;
    abort = ab;
    case (gmode)
      0:       gnt = 1'b1;
      1:       gnt = 1'($urandom_range(0, 1));
      default: gnt = 1'b0;
    endcase
    for (int k = 0; k < 3; k++) rdata[k] = hv[k][k] ? sram_byte(ha[k][k]) : 8'hEE;
    #1;
    cnum++;
    rel = cnum - t0;
    for (int k = 0; k < 3; k++) begin
      if (busy[k]) begin
        if (busy_n[k] == 0) first_busy[k] = rel;
        busy_n[k]++;
      end
      if (done[k]) begin done_n[k]++; done_rel[k] = rel; end
      if (wen[k]) begin tbuf[k][waddr[k]] = bwdata[k]; wen_n[k]++; last_wen[k] = rel; end
      if (req[k] && gnt) begin
        if (we[k]) begin
          if (wr_n[k] == 0) first_wr[k] = rel;
          if (wr_n[k] < 32) begin wr_a[k][wr_n[k]] = addr[k]; wr_d[k][wr_n[k]] = wdata[k]; end
          wr_n[k]++;
        end else begin
          if (rd_n[k] < 64) rd_a[k][rd_n[k]] = addr[k];
          rd_n[k]++;
        end
      end
      if (stall_q[k] && (addr[k] !== stall_a[k] || wdata[k] !== stall_d[k])) stab_err[k]++;
      stall_q[k] = req[k] && !gnt;
      if (stall_q[k]) stall_n[k]++;
      stall_a[k] = addr[k];
      stall_d[k] = wdata[k];
      for (int j = 3; j > 0; j--) begin hv[k][j] = hv[k][j-1]; ha[k][j] = ha[k][j-1]; end
      hv[k][0] = req[k] && gnt && !we[k];
      ha[k][0] = addr[k];
    end
  endtask

  task automatic begin_tile(input logic [17:0] s, input logic [17:0] d);
    src_base = s;
    dst_base = d;
    row0     = s[10:8];
    clr_logs();
    t0 = cnum + 1;
    step(1'b1, 1'b0);
  endtask

  task automatic chk_tile(input int k, input logic [17:0] s, input logic [17:0] d,
                          input string nm);
    logic [17:0] ea;
    logic [15:0] ed;
    chk({nm, " reads"}, 32'(rd_n[k]), 32'd64);
    chk({nm, " buf_wen count"}, 32'(wen_n[k]), 32'd64);
    chk({nm, " writes"}, 32'(wr_n[k]), 32'd32);
    for (int i = 0; i < 64; i++) begin
      ea = s + 18'(256 * (i / 8)) + 18'(i % 8);
      chk($sformatf("%s rd_addr[%0d]", nm, i), 32'(rd_a[k][i]), 32'(ea));
      chk($sformatf("%s buf[%0d]", nm, i), 32'(tbuf[k][i]), 32'(i));
    end
    for (int w = 0; w < 32; w++) begin
      ea = d + 18'(w);
      ed = {8'(2 * w), 8'(2 * w + 1)};
      chk($sformatf("%s wr_addr[%0d]", nm, w), 32'(wr_a[k][w]), 32'(ea));
      chk($sformatf("%s wr_data[%0d]", nm, w), 32'(wr_d[k][w]), 32'(ed));
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; gnt = 1'b0; gmode = 0;
    src_base = '0; dst_base = '0; row0 = '0; cnum = 0; t0 = 0; checks = 0; passes = 0;
    for (int k = 0; k < 3; k++) begin
      rdata[k] = '0;
      for (int j = 0; j < 4; j++) begin hv[k][j] = 1'b0; ha[k][j] = '0; end
    end
    clr_logs();

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst busy%0d", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst req%0d", k), 32'(req[k]), 32'd0);
      chk($sformatf("rst done%0d", k), 32'(done[k]), 32'd0);
      chk($sformatf("rst addr%0d", k), 32'(addr[k]), 32'd0);
      chk($sformatf("rst wen%0d", k), 32'(wen[k]), 32'd0);
    end
    reset = 1'b1;

    // Nominal, RD_LAT=1, gnt held high
    gmode = 0;
    begin_tile(18'h00100, 18'h02000);
    repeat (119) step(1'b0, 1'b0);
    chk_tile(0, 18'h00100, 18'h02000, "nom");
    chk("nom word5", 32'(wr_d[0][5]), 32'h0A0B);
    chk("nom first busy", 32'(first_busy[0]), 32'd1);
    chk("nom busy cycles", 32'(busy_n[0]), 32'd99);
    chk("nom last buf_wen", 32'(last_wen[0]), 32'd65);
    chk("nom first drain", 32'(first_wr[0]), 32'd67);
    chk("nom done count", 32'(done_n[0]), 32'd1);
    chk("nom done cycle", 32'(done_rel[0]), 32'd99);
    chk("nom done cycle lat3", 32'(done_rel[2]), 32'd101);

    // Random grant, checked on RD_LAT=3
    gmode = 1;
    begin_tile(18'h00100, 18'h02000);
    for (int i = 0; i < 2000 && (done_n[0] == 0 || done_n[1] == 0 || done_n[2] == 0); i++)
      step(1'b0, 1'b0);
    gmode = 0;
    repeat (5) step(1'b0, 1'b0);
    chk_tile(2, 18'h00100, 18'h02000, "rnd");
    chk("rnd stalls seen", 32'(stall_n[2] > 0), 32'd1);
    chk("rnd stall stability", 32'(stab_err[2]), 32'd0);
    chk("rnd done count", 32'(done_n[2]), 32'd1);

    // Address wrap modulo 2^18
    begin_tile(18'h3FF00, 18'h3FFF0);
    repeat (119) step(1'b0, 1'b0);
    chk_tile(0, 18'h3FF00, 18'h3FFF0, "wrap");
    chk("wrap row7 first", 32'(rd_a[0][56]), 32'h00600);
    chk("wrap row7 last", 32'(rd_a[0][63]), 32'h00607);
    chk("wrap word15 addr", 32'(wr_a[0][15]), 32'h3FFFF);
    chk("wrap word16 addr", 32'(wr_a[0][16]), 32'h00000);
    chk("wrap word16 data", 32'(wr_d[0][16]), 32'h2021);

    // start during FILL and in the DONE cycle is ignored
    begin_tile(18'h00100, 18'h02000);
    repeat (9) step(1'b0, 1'b0);
    step(1'b1, 1'b0);                           // rel 10, FILL
    repeat (88) step(1'b0, 1'b0);
    step(1'b1, 1'b0);                           // rel 99, DONE of RD_LAT=1
    chk("ign done in cycle 99", 32'(done[0]), 32'd1);
    step(1'b0, 1'b0);
    chk("ign idle after done", 32'(busy[0]), 32'd0);
    repeat (15) step(1'b0, 1'b0);
    chk("ign done count", 32'(done_n[0]), 32'd1);
    chk("ign busy cycles", 32'(busy_n[0]), 32'd99);
    begin_tile(18'h00100, 18'h02000);
    step(1'b0, 1'b0);
    chk("ign restart busy", 32'(busy[0]), 32'd1);
    repeat (118) step(1'b0, 1'b0);
    chk("ign restart done count", 32'(done_n[0]), 32'd1);
    chk("ign restart done cycle", 32'(done_rel[0]), 32'd99);

    // abort in FILL after 10 grants, checked on RD_LAT=2
    begin_tile(18'h00100, 18'h02000);
    repeat (10) step(1'b0, 1'b0);
    chk("abt grants", 32'(rd_n[1]), 32'd10);
    step(1'b0, 1'b1);                           // rel 11
    chk("abt wen before", 32'(wen[1]), 32'd1);
    chk("abt waddr before", 32'(waddr[1]), 32'd8);
    step(1'b0, 1'b0);                           // rel 12
    chk("abt busy", 32'(busy[1]), 32'd0);
    chk("abt req", 32'(req[1]), 32'd0);
    chk("abt wen after", 32'(wen[1]), 32'd0);
    repeat (20) step(1'b0, 1'b0);
    chk("abt wen count", 32'(wen_n[1]), 32'd9);
    chk("abt busy cycles", 32'(busy_n[1]), 32'd11);
    chk("abt no done", 32'(done_n[1]), 32'd0);

    // reset mid-DRAIN
    begin_tile(18'h00100, 18'h02000);
    repeat (80) step(1'b0, 1'b0);
    chk("rd in drain", 32'(we[0]), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rd busy", 32'(busy[0]), 32'd0);
    chk("rd done", 32'(done[0]), 32'd0);
    chk("rd req", 32'(req[0]), 32'd0);
    chk("rd we", 32'(we[0]), 32'd0);
    chk("rd addr", 32'(addr[0]), 32'd0);
    chk("rd wdata", 32'(wdata[0]), 32'd0);
    chk("rd buf_wen", 32'(wen[0]), 32'd0);
    chk("rd buf_waddr", 32'(waddr[0]), 32'd0);
    chk("rd buf_wdata", 32'(bwdata[0]), 32'd0);
    chk("rd buf_raddr", 32'(raddr[0]), 32'd0);
    repeat (2) step(1'b0, 1'b0);
    reset = 1'b1;
    clr_logs();
    repeat (10) step(1'b0, 1'b0);
    chk("rd stays idle", 32'(busy_n[0]), 32'd0);
    chk("rd no reads", 32'(rd_n[0]), 32'd0);
    begin_tile(18'h00100, 18'h02000);
    repeat (119) step(1'b0, 1'b0);
    chk("rd after done count", 32'(done_n[0]), 32'd1);
    chk("rd after done cycle", 32'(done_rel[0]), 32'd99);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
